// File: rtl/dwrr.sv
// dwrr: deficit-weighted round-robin scheduler with a one-hot, same-cycle pop grant.
// Define DWRR_DEFICIT_CLEAR_EN to zero an idle queue's deficit when the pointer leaves it.
module dwrr #(
  parameter int NUM_REQS = 4,
  parameter int QWID     = 128,
  parameter int PSIZE    = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS*QWID-1:0] input_quantums,
  output logic [NUM_REQS-1:0]      gnt
);

  localparam int PW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
  localparam logic [QWID-1:0] COST = QWID'(PSIZE);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            act_q, act_d;
  logic [QWID-1:0] def_q [NUM_REQS];
  logic [QWID-1:0] def_d [NUM_REQS];

  logic [PW-1:0]   sel;
  logic [PW-1:0]   nxt;
  logic [QWID-1:0] cur_def;
  logic [QWID-1:0] qsel;
  logic [QWID:0]   sum;
  logic [QWID-1:0] sum_sat;
  logic            elig;

  assign cur_def = def_q[ptr_q];
  assign elig    = act_q & reqs[ptr_q] & (cur_def >= COST);
  assign nxt     = (ptr_q == PW'(NUM_REQS - 1)) ? '0 : ptr_q + 1'b1;

  // First requester at or after ptr, with wrap; lowest offset wins.
  always_comb begin
    sel = ptr_q;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (reqs[(int'(ptr_q) + k) % NUM_REQS]) begin
        sel = PW'((int'(ptr_q) + k) % NUM_REQS);
      end
    end
  end

  assign qsel    = input_quantums[int'(sel)*QWID +: QWID];
  assign sum     = {1'b0, def_q[sel]} + {1'b0, qsel};
  assign sum_sat = sum[QWID] ? '1 : sum[QWID-1:0];

  always_comb begin
    gnt = '0;
    if (elig && !blk) begin
      gnt[ptr_q] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    act_d = act_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      def_d[i] = def_q[i];
    end
    if (!act_q) begin
      if (|reqs) begin
        ptr_d      = sel;
        act_d      = 1'b1;
        def_d[sel] = sum_sat;
      end
    end else if (elig) begin
      if (!blk) begin
        def_d[ptr_q] = cur_def - COST;
      end
    end else begin
      ptr_d = nxt;
      act_d = 1'b0;
`ifdef DWRR_DEFICIT_CLEAR_EN
      if (!reqs[ptr_q]) begin
        def_d[ptr_q] = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
      act_q <= 1'b0;
      for (int i = 0; i < NUM_REQS; i++) begin
        def_q[i] <= '0;
      end
    end else begin
      ptr_q <= ptr_d;
      act_q <= act_d;
      for (int i = 0; i < NUM_REQS; i++) begin
        def_q[i] <= def_d[i];
      end
    end
  end

endmodule

// File: tb/tb_dwrr.sv
// tb_dwrr: randomized and directed checks of dwrr against a round-based model.
// Honours DWRR_DEFICIT_CLEAR_EN the same way as the design.
module tb_dwrr;

  localparam int N    = 4;
  localparam int QW   = 8;
  localparam int PS   = 8;
  localparam int MAXV = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk;
  logic [N-1:0]  reqs;
  logic [N-1:0]  gnt;
  logic [QW-1:0] qv [N];
  logic [N*QW-1:0] iq;

  int total = 0;
  int bad   = 0;

  int m_ptr;
  bit m_act;
  int m_def [N];

  assign iq = {qv[3], qv[2], qv[1], qv[0]};

  always #5 clk = ~clk;

  dwrr #(
    .NUM_REQS(N),
    .QWID(QW),
    .PSIZE(PS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .blk(blk),
    .reqs(reqs),
    .input_quantums(iq),
    .gnt(gnt)
  );

  function automatic void m_reset();
    m_ptr = 0;
    m_act = 0;
    for (int i = 0; i < N; i++) m_def[i] = 0;
  endfunction

  function automatic logic [N-1:0] m_gnt();
    logic [N-1:0] g;
    g = '0;
    if (m_act && reqs[m_ptr] && m_def[m_ptr] >= PS && !blk) g[m_ptr] = 1'b1;
    return g;
  endfunction

  function automatic void m_step();
    int idx;
    if (!m_act) begin
      if (reqs != 0) begin
        idx = -1;
        for (int k = 0; k < N; k++) begin
          if (idx < 0 && reqs[(m_ptr + k) % N]) idx = (m_ptr + k) % N;
        end
        m_ptr = idx;
        m_def[idx] = m_def[idx] + int'(qv[idx]);
        if (m_def[idx] > MAXV) m_def[idx] = MAXV;
        m_act = 1;
      end
    end else if (reqs[m_ptr] && m_def[m_ptr] >= PS) begin
      if (!blk) m_def[m_ptr] = m_def[m_ptr] - PS;
    end else begin
`ifdef DWRR_DEFICIT_CLEAR_EN
      if (!reqs[m_ptr]) m_def[m_ptr] = 0;
`endif
      m_ptr = (m_ptr + 1) % N;
      m_act = 0;
    end
  endfunction

  task automatic tick(output logic [N-1:0] got, output logic [N-1:0] exp);
    @(negedge clk);
    got = gnt;
    exp = m_gnt();
    @(posedge clk);
    m_step();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic set_q(input int a, input int b, input int c, input int d);
    qv[0] = QW'(a);
    qv[1] = QW'(b);
    qv[2] = QW'(c);
    qv[3] = QW'(d);
  endtask

  task automatic test_reset();
    logic [N-1:0] got, exp;
    rst  = 1'b0;
    blk  = 1'b0;
    reqs = 4'hF;
    set_q(1, 1, 1, 1);
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (gnt !== 4'b0) begin
        bad++;
        $display("FAIL reset_hold: gnt=%b want=0000", gnt);
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(got, exp);
    total++;
    if (got !== 4'b0 || exp !== 4'b0) begin
      bad++;
      $display("FAIL reset_first_cycle: gnt=%b model=%b want=0000", got, exp);
    end
    for (int i = 0; i < 8; i++) begin
      tick(got, exp);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL reset_after[%0d]: gnt=%b want=%b", i, got, exp);
      end
    end
  endtask

  task automatic test_weights();
    logic [N-1:0] got, exp;
    int seq[$];
    int cnt[N];
    int want_seq[10] = '{0, 0, 1, 2, 3, 0, 0, 1, 2, 3};
    do_reset();
    set_q(16, 8, 8, 8);
    reqs = 4'hF;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 130; c++) begin
      tick(got, exp);
      total++;
      if (got !== exp || (got != 0 && !$onehot(got))) begin
        bad++;
        $display("FAIL weights_cyc[%0d]: gnt=%b want=%b", c, got, exp);
      end
      for (int i = 0; i < N; i++) begin
        if (got[i]) begin
          seq.push_back(i);
          cnt[i]++;
        end
      end
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (i >= seq.size() || seq[i] != want_seq[i]) begin
        bad++;
        $display("FAIL weights_order[%0d]: got=%0d want=%0d", i,
                 (i < seq.size()) ? seq[i] : -1, want_seq[i]);
      end
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (cnt[i] != ((i == 0) ? 20 : 10)) begin
        bad++;
        $display("FAIL weights_count[%0d]: got=%0d want=%0d", i, cnt[i],
                 (i == 0) ? 20 : 10);
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] got, exp;
    int n;
    do_reset();
    set_q(4, 0, 0, 0);
    reqs = 4'b0001;
    n = 0;
    for (int c = 0; c < 25; c++) begin
      tick(got, exp);
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL single_cyc[%0d]: gnt=%b want=%b", c, got, exp);
      end
      if (got == 4'b0001) n++;
    end
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL single_grants: got=%0d want=5", n);
    end
  endtask

  task automatic test_blk();
    logic [N-1:0] got, exp;
    logic [N-1:0] want [6] = '{4'b0, 4'b0, 4'b0, 4'b0010, 4'b0010, 4'b0};
    do_reset();
    set_q(0, 16, 0, 0);
    reqs = 4'b0010;
    tick(got, exp);
    total++;
    if (got !== 4'b0 || exp !== 4'b0) begin
      bad++;
      $display("FAIL blk_select: gnt=%b want=0000", got);
    end
    blk = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) blk = 1'b0;
      tick(got, exp);
      total++;
      if (got !== want[i] || got !== exp) begin
        bad++;
        $display("FAIL blk_step[%0d]: gnt=%b want=%b model=%b", i, got, want[i], exp);
      end
    end
  endtask

  task automatic test_clear();
    logic [N-1:0] got, exp;
    logic [N-1:0] want;
`ifdef DWRR_DEFICIT_CLEAR_EN
    want = 4'b0000;
`else
    want = 4'b0100;
`endif
    do_reset();
    set_q(0, 0, 4, 0);
    reqs = 4'b0100;
    tick(got, exp);
    reqs = 4'b0000;
    tick(got, exp);
    tick(got, exp);
    reqs = 4'b0100;
    tick(got, exp);
    total++;
    if (got !== 4'b0) begin
      bad++;
      $display("FAIL clear_reselect: gnt=%b want=0000", got);
    end
    tick(got, exp);
    total++;
    if (got !== want || got !== exp) begin
      bad++;
      $display("FAIL clear_deficit: gnt=%b want=%b model=%b", got, want, exp);
    end
  endtask

  task automatic test_midreset();
    logic [N-1:0] got, exp;
    do_reset();
    set_q(0, 0, 0, 8);
    reqs = 4'b1000;
    tick(got, exp);
    @(negedge clk);
    total++;
    if (gnt !== 4'b1000) begin
      bad++;
      $display("FAIL midreset_pre: gnt=%b want=1000", gnt);
    end
    #1;
    rst = 1'b0;
    m_reset();
    #1;
    total++;
    if (gnt !== 4'b0) begin
      bad++;
      $display("FAIL midreset_async: gnt=%b want=0000", gnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    qv[3] = 8'd4;
    tick(got, exp);
    tick(got, exp);
    total++;
    if (got !== 4'b0 || exp !== 4'b0) begin
      bad++;
      $display("FAIL midreset_cleared: gnt=%b want=0000", got);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] got, exp;
    int errs;
    do_reset();
    errs = 0;
    reqs = 4'hF;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) reqs = N'($urandom);
      blk = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < N; i++) begin
          qv[i] = ($urandom_range(0, 15) == 0) ? 8'd250 : QW'($urandom_range(0, 40));
        end
      end
      tick(got, exp);
      total++;
      if (got !== exp || (got != 0 && !$onehot(got))) begin
        bad++;
        errs++;
        if (errs < 10) $display("FAIL random_cyc[%0d]: gnt=%b want=%b", c, got, exp);
      end
    end
    blk = 1'b0;
  endtask

  initial begin
    test_reset();
    test_weights();
    test_single();
    test_blk();
    test_clear();
    test_midreset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
